// File: rtl/softmax_row_sum_if.sv
// Handshake bundle for softmax_row_sum: upstream score stream in, buffered
// score replay plus row sum out toward the normalizer PE chain.
interface softmax_row_sum_if;
    logic in_valid;
    logic in_ready;
    real  x_in;
    logic out_valid;
    logic out_ready;
    real  x_out;
    real  norm_out;
    logic row_last;

    modport slave (
        input  in_valid,
        input  x_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x_out,
        output norm_out,
        output row_last
    );

    modport master (
        output in_valid,
        output x_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x_out,
        input  norm_out,
        input  row_last
    );
endinterface

// File: rtl/softmax_row_sum.sv
// Buffers one row of exponentiated scores, accumulates their sum, then replays the row
// with the sum attached. Optional macro ROWSUM_ZERO_GUARD_EN turns a zero sum into 1.0.
module softmax_row_sum #(
    parameter int ROW_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    softmax_row_sum_if.slave bus
);
    localparam int ADDR_W = $clog2(ROW_LEN);
    localparam int IDX_W  = $clog2(ROW_LEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    real              r_sum;
    real              r_buf [ROW_LEN];

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_wr_last;
    logic w_rd_last;
    real  w_x_out;
    real  w_norm_out;
    logic w_row_last;

    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = w_out_valid & bus.out_ready;
    assign w_wr_last  = (r_wr_idx == LAST_IDX);
    assign w_rd_last  = (r_rd_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = S_ACCUM;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_wr_last) begin
                    w_next_state = S_EMIT;
                end else begin
                    w_next_state = S_ACCUM;
                end
            end
            S_EMIT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && w_rd_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_EMIT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_in_ready   = 1'b0;
                w_out_valid  = 1'b0;
            end
        endcase
    end

    // Sum and index counters; indices saturate at LAST_IDX and clear at end of row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum    <= 0.0;
            r_wr_idx <= {IDX_W{1'b0}};
            r_rd_idx <= {IDX_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_sum    <= bus.x_in;
                        r_wr_idx <= IDX_W'(1);
                        r_rd_idx <= {IDX_W{1'b0}};
                    end
                end
                S_ACCUM: begin
                    if (w_in_xfer) begin
                        r_sum <= r_sum + bus.x_in;
                        if (w_wr_last) begin
                            r_rd_idx <= {IDX_W{1'b0}};
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_xfer) begin
                        if (w_rd_last) begin
                            r_wr_idx <= {IDX_W{1'b0}};
                            r_rd_idx <= {IDX_W{1'b0}};
                        end else begin
                            r_rd_idx <= r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_wr_idx <= {IDX_W{1'b0}};
                    r_rd_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Row buffer; contents are don't-care after reset because wr_idx restarts at 0
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_buf[r_wr_idx[ADDR_W-1:0]] <= bus.x_in;
        end
    end

    // Output view: only meaningful in EMIT, forced to zero otherwise
    always_comb begin
        w_x_out    = 0.0;
        w_norm_out = 0.0;
        w_row_last = 1'b0;
        if (r_state == S_EMIT) begin
            w_x_out    = r_buf[r_rd_idx[ADDR_W-1:0]];
            w_row_last = w_rd_last;
`ifdef ROWSUM_ZERO_GUARD_EN
            if (r_sum == 0.0) begin
                w_norm_out = 1.0;
            end else begin
                w_norm_out = r_sum;
            end
`else
            w_norm_out = r_sum;
`endif
        end else begin
            w_x_out    = 0.0;
            w_norm_out = 0.0;
            w_row_last = 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.x_out     = w_x_out;
    assign bus.norm_out  = w_norm_out;
    assign bus.row_last  = w_row_last;

endmodule

// File: tb/tb_softmax_row_sum.sv
// Self-checking bench for softmax_row_sum: directed and random rows against a
// queue-based row model; honours ROWSUM_ZERO_GUARD_EN for the expected row sum.
module tb_softmax_row_sum;
    localparam int ROW_LEN = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    real  m_row[$];
    real  q[$];

    always #5 clk = ~clk;

    softmax_row_sum_if u_if ();

    softmax_row_sum #(.ROW_LEN(ROW_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk_b({tag, "_in_ready"}, u_if.in_ready, 1'b1);
        chk_b({tag, "_out_valid"}, u_if.out_valid, 1'b0);
        chk_b({tag, "_row_last"}, u_if.row_last, 1'b0);
        chk_r({tag, "_x_out"}, u_if.x_out, 0.0);
        chk_r({tag, "_norm_out"}, u_if.norm_out, 0.0);
    endtask

    // Offer each value once; gap idle cycles between accepts while the row is open
    task automatic send_vals(input real vals[$], input int gap);
        foreach (vals[i]) begin
            u_if.in_valid = 1'b1;
            u_if.x_in     = vals[i];
            chk_b("in_ready_offer", u_if.in_ready, 1'b1);
            tick();
            m_row.push_back(vals[i]);
            u_if.in_valid = 1'b0;
            chk_b("out_valid_after_accept", u_if.out_valid, m_row.size() == ROW_LEN);
            if (m_row.size() < ROW_LEN) begin
                for (int g = 0; g < gap; g++) begin
                    chk_b("accum_in_ready", u_if.in_ready, 1'b1);
                    chk_b("accum_out_valid", u_if.out_valid, 1'b0);
                    tick();
                end
            end
        end
        u_if.in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, other: random
    task automatic drain(input int mode, input bit keep_valid, input real next_x);
        real exp_sum;
        real exp_norm;
        int  k;
        int  cyc;
        bit  rdy;
        exp_sum = 0.0;
        foreach (m_row[i]) exp_sum = exp_sum + m_row[i];
        exp_norm = exp_sum;
`ifdef ROWSUM_ZERO_GUARD_EN
        if (exp_sum == 0.0) exp_norm = 1.0;
`endif
        u_if.in_valid = keep_valid;
        u_if.x_in     = next_x;
        k   = 0;
        cyc = 0;
        while (k < ROW_LEN && cyc < 64) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            else rdy = 1'($urandom_range(0, 1));
            u_if.out_ready = rdy;
            chk_b("emit_out_valid", u_if.out_valid, 1'b1);
            chk_b("emit_in_ready", u_if.in_ready, 1'b0);
            chk_r("emit_x_out", u_if.x_out, m_row[k]);
            chk_r("emit_norm_out", u_if.norm_out, exp_norm);
            chk_b("emit_row_last", u_if.row_last, k == ROW_LEN - 1);
            tick();
            if (rdy) k++;
            cyc++;
        end
        chk_b("drain_complete", k == ROW_LEN, 1'b1);
        u_if.out_ready = 1'b0;
        chk_quiet("post_row");
        m_row.delete();
    endtask

    task automatic reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        chk_quiet("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        m_row.delete();
        chk_quiet("after_reset");
    endtask

    task automatic rand_row();
        q.delete();
        for (int i = 0; i < ROW_LEN; i++) q.push_back(real'($urandom_range(0, 255)) / 4.0);
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.x_in      = 0.0;
        u_if.out_ready = 1'b0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset_state");
        reset = 1'b0;
        tick();
        chk_quiet("idle");

        q = {1.0, 2.0, 3.0, 4.0};
        send_vals(q, 0);
        drain(0, 1'b0, 0.0);

        q = {0.5, 0.5, 1.0, 2.0};
        send_vals(q, 3);
        drain(0, 1'b0, 0.0);

        rand_row();
        send_vals(q, 0);
        drain(1, 1'b0, 0.0);

        q = {7.0, 9.0};
        send_vals(q, 1);
        reset_pulse();
        q = {2.0, 2.0, 2.0, 2.0};
        send_vals(q, 0);
        drain(0, 1'b0, 0.0);

        q = {5.0, 6.0, 7.0, 8.0};
        send_vals(q, 0);
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk_r("emit_second_x", u_if.x_out, 6.0);
        reset_pulse();

        q = {0.0, 0.0, 0.0, 0.0};
        send_vals(q, 2);
        drain(2, 1'b0, 0.0);

        rand_row();
        send_vals(q, 0);
        rand_row();
        drain(0, 1'b1, q[0]);
        send_vals(q, 0);
        drain(2, 1'b0, 0.0);

        for (int r = 0; r < 5; r++) begin
            rand_row();
            send_vals(q, $urandom_range(0, 2));
            drain(2, 1'b0, 0.0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
